input4_or_b: RTL and testbench

//  - 4-input OR built as a tree of three 2-input ORs, exposing both partial terms and the final OR.
//  - e = a|b, f = c|d, g = e|f = a|b|c|d.
//  - Leaf logic primitive for lab/glue logic. Outputs are registered so the block is a clean, synchronous leaf cell.

---
 rtl/input4_or_b_pkg.sv | 4 +
 rtl/input4_or_b_if.sv | 10 +
 rtl/input4_or_b_or2_cell.sv | 10 +
 rtl/input4_or_b.sv | 29 ++
 tb/tb_input4_or_b.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/input4_or_b_pkg.sv
// input4_or_b_pkg: shared default lane width for the 4-input OR slice
package input4_or_b_pkg;
  localparam int DEF_W = 1;
endpackage

// File: rtl/input4_or_b_if.sv
// input4_or_b_if: OR bus; master drives a,b,c,d and reads e=a|b, f=c|d, g=a|b|c|d
interface input4_or_b_if
  import input4_or_b_pkg::*;
#(
  parameter int W = DEF_W
);
  logic [W-1:0] a, b, c, d, e, f, g;
  modport master (output a, b, c, d, input e, f, g);
  modport slave (input a, b, c, d, output e, f, g);
endinterface

// File: rtl/input4_or_b_or2_cell.sv
// or2_cell: bitwise 2-input OR; ports x0, x1 in, y out
module or2_cell #(
  parameter int W = 1
) (
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  output logic [W-1:0] y
);
  assign y = x0 | x1;
endmodule

// File: rtl/input4_or_b.sv
// input4_or_b: OR tree e=a|b, f=c|d, g=e|f, optionally registered; ports clk, rst_n, bus (slave)
module input4_or_b
  import input4_or_b_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter bit REG_OUT = 1'b1
) (
  input logic clk,
  input logic rst_n,
  input4_or_b_if.slave bus
);
  logic [W-1:0] ab, cd, abcd;
  or2_cell #(.W(W)) u_ab (.x0(bus.a), .x1(bus.b), .y(ab));
  or2_cell #(.W(W)) u_cd (.x0(bus.c), .x1(bus.d), .y(cd));
  or2_cell #(.W(W)) u_g  (.x0(ab),    .x1(cd),    .y(abcd));
  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk) begin
        bus.e <= rst_n ? ab : '0;
        bus.f <= rst_n ? cd : '0;
        bus.g <= rst_n ? abcd : '0;
      end
    end else begin : g_comb
      assign bus.e = ab;
      assign bus.f = cd;
      assign bus.g = abcd;
    end
  endgenerate
endmodule

// File: tb/tb_input4_or_b.sv
// tb_input4_or_b: directed checks of registered W=1, registered W=4 and combinational OR trees
module tb_input4_or_b;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  input4_or_b_if #(.W(1)) b1 ();
  input4_or_b_if #(.W(4)) b4 ();
  input4_or_b_if #(.W(1)) bc ();
  input4_or_b #(.W(1), .REG_OUT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  input4_or_b #(.W(4), .REG_OUT(1'b1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  input4_or_b #(.W(1), .REG_OUT(1'b0)) dutc (.clk(clk), .rst_n(rst_n), .bus(bc.slave));

  task automatic drive1(input logic [3:0] v);
    {b1.a, b1.b, b1.c, b1.d} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive1(4'b1111);
    {b4.a, b4.b, b4.c, b4.d} = {4'hf, 4'hf, 4'hf, 4'hf};
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({b1.e, b1.f, b1.g} !== 3'b000) begin
      bad++;
      $display("FAIL reset_w1 efg got=%b exp=000", {b1.e, b1.f, b1.g});
    end
    total++;
    if ({b4.e, b4.f, b4.g} !== 12'h000) begin
      bad++;
      $display("FAIL reset_w4 efg got=%h exp=000", {b4.e, b4.f, b4.g});
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({b1.e, b1.f, b1.g} !== 3'b111) begin
      bad++;
      $display("FAIL reset_release efg got=%b exp=111", {b1.e, b1.f, b1.g});
    end
  endtask

  task automatic test_truth_table();
    logic [3:0] v;
    logic [2:0] exp;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      exp = {v[3] | v[2], v[1] | v[0], |v};
      drive1(v);
      tick();
      total++;
      if ({b1.e, b1.f, b1.g} !== exp) begin
        bad++;
        $display("FAIL truth abcd=%b efg got=%b exp=%b", v, {b1.e, b1.f, b1.g}, exp);
      end
    end
  endtask

  task automatic test_lanes();
    {b4.a, b4.b, b4.c, b4.d} = {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    tick();
    total++;
    if ({b4.e, b4.f, b4.g} !== {4'b0011, 4'b1100, 4'b1111}) begin
      bad++;
      $display("FAIL lanes_onehot efg got=%b exp=001111001111", {b4.e, b4.f, b4.g});
    end
    {b4.a, b4.b, b4.c, b4.d} = {4'b0000, 4'b0000, 4'b1010, 4'b0000};
    tick();
    total++;
    if ({b4.e, b4.f, b4.g} !== {4'b0000, 4'b1010, 4'b1010}) begin
      bad++;
      $display("FAIL lanes_c_only efg got=%b exp=000010101010", {b4.e, b4.f, b4.g});
    end
    {b4.a, b4.b, b4.c, b4.d} = {4'b1001, 4'b0000, 4'b0000, 4'b0110};
    tick();
    total++;
    if ({b4.e, b4.f, b4.g} !== {4'b1001, 4'b0110, 4'b1111}) begin
      bad++;
      $display("FAIL lanes_ad efg got=%b exp=100101101111", {b4.e, b4.f, b4.g});
    end
  endtask

  task automatic test_midstream_reset();
    drive1(4'b1000);
    tick();
    total++;
    if ({b1.e, b1.f, b1.g} !== 3'b101) begin
      bad++;
      $display("FAIL mid_pre0 efg got=%b exp=101", {b1.e, b1.f, b1.g});
    end
    drive1(4'b0100);
    tick();
    total++;
    if ({b1.e, b1.f, b1.g} !== 3'b101) begin
      bad++;
      $display("FAIL mid_pre1 efg got=%b exp=101", {b1.e, b1.f, b1.g});
    end
    drive1(4'b0010);
    rst_n = 1'b0;
    tick();
    total++;
    if ({b1.e, b1.f, b1.g} !== 3'b000) begin
      bad++;
      $display("FAIL mid_rst efg got=%b exp=000", {b1.e, b1.f, b1.g});
    end
    rst_n = 1'b1;
    drive1(4'b0001);
    tick();
    total++;
    if ({b1.e, b1.f, b1.g} !== 3'b011) begin
      bad++;
      $display("FAIL mid_post efg got=%b exp=011", {b1.e, b1.f, b1.g});
    end
    drive1(4'b1100);
    tick();
    total++;
    if ({b1.e, b1.f, b1.g} !== 3'b101) begin
      bad++;
      $display("FAIL mid_post2 efg got=%b exp=101", {b1.e, b1.f, b1.g});
    end
  endtask

  task automatic test_comb();
    logic [3:0] vec [4] = '{4'b0010, 4'b1000, 4'b0000, 4'b0101};
    logic [2:0] exp [4] = '{3'b011, 3'b101, 3'b000, 3'b111};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      {bc.a, bc.b, bc.c, bc.d} = vec[i];
      #1;
      total++;
      if ({bc.e, bc.f, bc.g} !== exp[i]) begin
        bad++;
        $display("FAIL comb abcd=%b efg got=%b exp=%b", vec[i], {bc.e, bc.f, bc.g}, exp[i]);
      end
    end
  endtask

  initial begin
    drive1(4'b0000);
    {b4.a, b4.b, b4.c, b4.d} = '0;
    {bc.a, bc.b, bc.c, bc.d} = '0;
    test_reset();
    test_truth_table();
    test_lanes();
    test_midstream_reset();
    test_comb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
